// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// counter-word layout, C-select field placement and FSM encodings.
package pll_cfg_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CW_W     = 18;
    localparam int unsigned CSEL_LSB = 18;
    localparam int unsigned CSEL_W   = 5;

    localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'd0;
    localparam logic [ADDR_W-1:0] ADDR_START = 6'd2;
    localparam logic [ADDR_W-1:0] ADDR_N     = 6'd3;
    localparam logic [ADDR_W-1:0] ADDR_M     = 6'd4;
    localparam logic [ADDR_W-1:0] ADDR_C     = 6'd5;
    localparam logic [ADDR_W-1:0] ADDR_K     = 6'd7;
    localparam logic [ADDR_W-1:0] ADDR_BW    = 6'd8;
    localparam logic [ADDR_W-1:0] ADDR_CP    = 6'd9;

    // 18-bit counter word: {odd, bypass, hi[7:0], lo[7:0]}
    typedef struct packed {
        logic       odd;
        logic       bypass;
        logic [7:0] hi;
        logic [7:0] lo;
    } cnt_word_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_LOCK = 2'd2,
        FINISH    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        WR_MODE  = 3'd0,
        WR_N     = 3'd1,
        WR_M     = 3'd2,
        WR_K     = 3'd3,
        WR_C     = 3'd4,
        WR_BW    = 3'd5,
        WR_CP    = 3'd6,
        WR_START = 3'd7
    } wr_step_e;

    function automatic logic [DATA_W-1:0] c_write_data(input logic [CSEL_W-1:0] idx,
                                                       input logic [CW_W-1:0]   word);
        logic [DATA_W-1:0] d;
        d = 32'd0;
        d[CSEL_LSB +: CSEL_W] = idx;
        d[CW_W-1:0] = word;
        return d;
    endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Synchronises pll_locked and, while enabled, tracks the consecutive-lock run
// and the elapsed-cycle budget; both counters saturate and clear when disabled.
module pll_lock_monitor #(
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pll_locked,
    output logic lock_ok,
    output logic lock_timeout
);

    localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    logic [1:0]        sync_q,   sync_d;
    logic [STAB_W-1:0] stable_q, stable_d;
    logic [TMO_W-1:0]  tmo_q,    tmo_d;

    // Next-state for synchroniser and both counters
    always_comb begin
        sync_d   = {sync_q[0], pll_locked};
        stable_d = stable_q;
        tmo_d    = tmo_q;
        if (!en) begin
            stable_d = {STAB_W{1'b0}};
            tmo_d    = {TMO_W{1'b0}};
        end else begin
            if (!sync_q[1]) begin
                stable_d = {STAB_W{1'b0}};
            end else if (stable_q != STAB_MAX) begin
                stable_d = stable_q + STAB_ONE;
            end else begin
                stable_d = stable_q;
            end
            if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + TMO_ONE;
            end else begin
                tmo_d = tmo_q;
            end
        end
    end

    // Flags fire on the cycle that completes the run or the budget
    always_comb begin
        lock_ok      = en && sync_q[1] && (stable_q == STAB_MAX - STAB_ONE);
        lock_timeout = en && (tmo_q == TMO_MAX - TMO_ONE);
    end

    // Synchroniser and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            stable_q <= {STAB_W{1'b0}};
            tmo_q    <= {TMO_W{1'b0}};
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: captures a request, writes the register list
// over Avalon-MM, then waits for a stable lock and reports done or error.
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int unsigned NUM_C        = 2,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 1048576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CW_W-1:0]       cfg_n,
    input  logic [CW_W-1:0]       cfg_m,
    input  logic [31:0]           cfg_k,
    input  logic [CW_W*NUM_C-1:0] cfg_c,
    input  logic [3:0]            cfg_bw,
    input  logic [2:0]            cfg_cp,
    input  logic                  cfg_bwcp_en,
    output logic [ADDR_W-1:0]     mgmt_address,
    output logic                  mgmt_write,
    output logic [DATA_W-1:0]     mgmt_writedata,
    output logic                  mgmt_read,
    input  logic                  mgmt_waitrequest,
    input  logic                  pll_locked,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [CSEL_W-1:0] CIDX_LAST = CSEL_W'(NUM_C - 1);
    localparam logic [CSEL_W-1:0] CIDX_ONE  = CSEL_W'(1);

    state_e                  state_q, state_d;
    wr_step_e                step_q,  step_d, nstep_s;
    logic [CSEL_W-1:0]       cidx_q,  cidx_d, ncidx_s;
    cnt_word_t               n_q, n_d, m_q, m_d;
    logic [31:0]             k_q, k_d;
    logic [CW_W*NUM_C-1:0]   c_q, c_d;
    logic [3:0]              bw_q, bw_d;
    logic [2:0]              cp_q, cp_d;
    logic                    bwcp_en_q, bwcp_en_d;
    logic                    ready_q, ready_d;
    logic                    wr_q, wr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [ADDR_W-1:0]       waddr_s;
    logic [DATA_W-1:0]       wdata_s;
    logic [CW_W-1:0]         cword_s;
    logic                    lock_en_s, lock_ok_s, lock_timeout_s;

    assign lock_en_s = (state_q == WAIT_LOCK);

    pll_lock_monitor #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_mon (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (lock_en_s),
        .pll_locked   (pll_locked),
        .lock_ok      (lock_ok_s),
        .lock_timeout (lock_timeout_s)
    );

    // Select the C counter word addressed by the current index
    always_comb begin
        cword_s = {CW_W{1'b0}};
        for (int i = 0; i < int'(NUM_C); i++) begin
            if (cidx_q == CSEL_W'(i)) begin
                cword_s = c_q[i*CW_W +: CW_W];
            end else begin
                cword_s = cword_s;
            end
        end
    end

    // Address/data of the current list entry and the entry that follows it
    always_comb begin
        waddr_s = ADDR_START;
        wdata_s = 32'd1;
        nstep_s = WR_START;
        ncidx_s = cidx_q;
        case (step_q)
            WR_MODE: begin waddr_s = ADDR_MODE; wdata_s = 32'd0;           nstep_s = WR_N; end
            WR_N:    begin waddr_s = ADDR_N;    wdata_s = {14'd0, n_q};    nstep_s = WR_M; end
            WR_M:    begin waddr_s = ADDR_M;    wdata_s = {14'd0, m_q};    nstep_s = WR_K; end
            WR_K: begin
                waddr_s = ADDR_K;
                wdata_s = k_q;
                nstep_s = WR_C;
                ncidx_s = {CSEL_W{1'b0}};
            end
            WR_C: begin
                waddr_s = ADDR_C;
                wdata_s = c_write_data(cidx_q, cword_s);
                if (cidx_q != CIDX_LAST) begin
                    nstep_s = WR_C;
                    ncidx_s = cidx_q + CIDX_ONE;
                end else if (bwcp_en_q) begin
                    nstep_s = WR_BW;
                end else begin
                    nstep_s = WR_START;
                end
            end
            WR_BW:    begin waddr_s = ADDR_BW;    wdata_s = {28'd0, bw_q}; nstep_s = WR_CP;    end
            WR_CP:    begin waddr_s = ADDR_CP;    wdata_s = {29'd0, cp_q}; nstep_s = WR_START; end
            WR_START: begin waddr_s = ADDR_START; wdata_s = 32'd1;         nstep_s = WR_START; end
            default:  begin waddr_s = ADDR_START; wdata_s = 32'd1;         nstep_s = WR_START; end
        endcase
    end

    // Sequencer next-state and registered output values
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cidx_d    = cidx_q;
        n_d       = n_q;
        m_d       = m_q;
        k_d       = k_q;
        c_d       = c_q;
        bw_d      = bw_q;
        cp_d      = cp_q;
        bwcp_en_d = bwcp_en_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                wr_d = 1'b0;
                if (cfg_valid && ready_q) begin
                    n_d       = cfg_n;
                    m_d       = cfg_m;
                    k_d       = cfg_k;
                    c_d       = cfg_c;
                    bw_d      = cfg_bw;
                    cp_d      = cfg_cp;
                    bwcp_en_d = cfg_bwcp_en;
                    state_d   = WRITE;
                    step_d    = WR_MODE;
                    cidx_d    = {CSEL_W{1'b0}};
                    wr_d      = 1'b1;
                    addr_d    = ADDR_MODE;
                    data_d    = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_q) begin
                    // Bus fields stay frozen until the slave drops waitrequest
                    if (!mgmt_waitrequest) begin
                        wr_d = 1'b0;
                        if (step_q == WR_START) begin
                            state_d = WAIT_LOCK;
                        end else begin
                            step_d = nstep_s;
                            cidx_d = ncidx_s;
                        end
                    end else begin
                        wr_d = 1'b1;
                    end
                end else begin
                    wr_d   = 1'b1;
                    addr_d = waddr_s;
                    data_d = wdata_s;
                end
            end
            WAIT_LOCK: begin
                if (lock_ok_s) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (lock_timeout_s) begin
                    state_d = FINISH;
                    error_d = 1'b1;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // State, captured request and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= WR_MODE;
            cidx_q    <= {CSEL_W{1'b0}};
            n_q       <= '{1'b0, 1'b0, 8'd0, 8'd0};
            m_q       <= '{1'b0, 1'b0, 8'd0, 8'd0};
            k_q       <= 32'd0;
            c_q       <= {(CW_W*NUM_C){1'b0}};
            bw_q      <= 4'd0;
            cp_q      <= 3'd0;
            bwcp_en_q <= 1'b0;
            ready_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 6'd0;
            data_q    <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cidx_q    <= cidx_d;
            n_q       <= n_d;
            m_q       <= m_d;
            k_q       <= k_d;
            c_q       <= c_d;
            bw_q      <= bw_d;
            cp_q      <= cp_d;
            bwcp_en_q <= bwcp_en_d;
            ready_q   <= ready_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign cfg_ready      = ready_q;
    assign mgmt_write     = wr_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign mgmt_read      = 1'b0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Scoreboard bench for pll_cfg_seq: requests push expected writes and a lock
// outcome; a negedge monitor pops and compares as the DUT presents them.
module tb_pll_cfg_seq;

    localparam int NUM_C        = 2;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 100;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [17:0]           cfg_n = 18'd0, cfg_m = 18'd0;
    logic [31:0]           cfg_k = 32'd0;
    logic [18*NUM_C-1:0]   cfg_c = '0;
    logic [3:0]            cfg_bw = 4'd0;
    logic [2:0]            cfg_cp = 3'd0;
    logic                  cfg_bwcp_en = 1'b0;
    logic [5:0]            mgmt_address;
    logic                  mgmt_write;
    logic [31:0]           mgmt_writedata;
    logic                  mgmt_read;
    logic                  mgmt_waitrequest = 1'b0;
    logic                  pll_locked = 1'b1;
    logic                  busy, done, error;

    always #5 clk = ~clk;

    pll_cfg_seq #(.NUM_C(NUM_C), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c),
        .cfg_bw(cfg_bw), .cfg_cp(cfg_cp), .cfg_bwcp_en(cfg_bwcp_en),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
        .mgmt_read(mgmt_read), .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
        .busy(busy), .done(done), .error(error)
    );

    typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;

    int  tests = 0, fails = 0;
    wr_t exp_wr_q[$];
    bit  st_pending = 1'b0, st_armed = 1'b0, exp_st_done = 1'b0;
    int  exp_st_k = 0, st_cycle = 0;
    int  lock_mode = 0, lock_glitch = 0, lock_base = 0;
    bit  lock_active = 1'b0;
    int  wait_mode = 0;
    bit  check_m_len = 1'b0;
    int  cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lock level the DUT samples on the rel-th edge after the start write completes
    function automatic bit lock_level(input int rel);
        if (lock_mode == 2) return 1'b0;
        if (lock_mode == 1 && rel == lock_glitch) return 1'b0;
        return 1'b1;
    endfunction

    // Outcome: first cycle in WAIT_LOCK that ends a run of LOCK_STABLE
    // synchronised-high cycles, else timeout after LOCK_TIMEOUT cycles
    task automatic predict(output bit is_done, output int k);
        int run;
        run = 0;
        is_done = 1'b0;
        k = LOCK_TIMEOUT;
        for (int c = 1; c <= LOCK_TIMEOUT; c++) begin
            run = lock_level(c - 2) ? run + 1 : 0;
            if (run >= LOCK_STABLE) begin
                is_done = 1'b1;
                k = c;
                return;
            end
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Waitrequest driver: stretches each new write according to wait_mode
    initial begin
        int  left;
        bit  seen;
        left = 0;
        seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                left = 0;
                seen = 1'b0;
                mgmt_waitrequest = 1'b0;
            end else begin
                if (mgmt_write && !seen) begin
                    if (wait_mode == 1) left = (mgmt_address == 6'd4) ? 5 : 0;
                    else if (wait_mode == 2) left = $urandom_range(0, 3);
                    else left = 0;
                end
                seen = mgmt_write;
                if (mgmt_write && left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                end
            end
        end
    end

    // Monitor: write handshakes, hold rules, status pulses; also drives pll_locked
    initial begin
        bit  acc_pend, after_hs, prev_hold, chk_idle;
        logic [5:0]  prev_a;
        logic [31:0] prev_d;
        int  wr_len;
        wr_t e;
        acc_pend = 0; after_hs = 0; prev_hold = 0; chk_idle = 0; wr_len = 0;
        prev_a = 6'd0; prev_d = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                acc_pend = 0; after_hs = 0; prev_hold = 0; chk_idle = 0; wr_len = 0;
                st_armed = 1'b0;
                lock_active = 1'b0;
            end else begin
                if (acc_pend) begin
                    check("first_write_latency", {31'd0, mgmt_write}, 32'd1);
                    check("busy_after_accept", {31'd0, busy}, 32'd1);
                    check("ready_low_when_busy", {31'd0, cfg_ready}, 32'd0);
                    acc_pend = 0;
                end
                if (cfg_valid && cfg_ready) acc_pend = 1;
                check("mgmt_read_zero", {31'd0, mgmt_read}, 32'd0);
                if (after_hs) begin
                    check("idle_gap", {31'd0, mgmt_write}, 32'd0);
                    after_hs = 0;
                end
                if (prev_hold) begin
                    check("held_addr", {25'd0, mgmt_write, mgmt_address}, {25'd0, 1'b1, prev_a});
                    check("held_data", mgmt_writedata, prev_d);
                end
                prev_hold = 0;
                if (mgmt_write) wr_len++;
                if (mgmt_write && mgmt_waitrequest) begin
                    prev_hold = 1;
                    prev_a = mgmt_address;
                    prev_d = mgmt_writedata;
                end
                if (mgmt_write && !mgmt_waitrequest) begin
                    if (exp_wr_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected",
                                 mgmt_address, mgmt_writedata);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check("write_addr", {26'd0, mgmt_address}, {26'd0, e.a});
                        check("write_data", mgmt_writedata, e.d);
                    end
                    if (check_m_len && mgmt_address == 6'd4) check("m_write_cycles", wr_len, 32'd6);
                    wr_len = 0;
                    after_hs = 1;
                    if (mgmt_address == 6'd2 && st_pending) begin
                        st_armed = 1'b1;
                        st_cycle = cyc + exp_st_k + 1;
                        lock_active = 1'b1;
                        lock_base = cyc;
                    end
                end
                if (chk_idle) begin
                    check("busy_low_after_finish", {31'd0, busy}, 32'd0);
                    check("ready_after_finish", {31'd0, cfg_ready}, 32'd1);
                    chk_idle = 0;
                end
                if (st_armed && cyc == st_cycle) begin
                    check("done_pulse", {31'd0, done}, {31'd0, exp_st_done});
                    check("error_pulse", {31'd0, error}, {31'd0, !exp_st_done});
                    check("busy_in_finish", {31'd0, busy}, 32'd1);
                    st_armed = 1'b0;
                    st_pending = 1'b0;
                    lock_active = 1'b0;
                    chk_idle = 1;
                end else if (done || error) begin
                    tests++; fails++;
                    $display("FAIL unexpected_status: done=%0d error=%0d at cycle %0d", done, error, cyc);
                end
            end
            pll_locked = lock_active ? lock_level(cyc - lock_base) : (lock_mode != 2);
        end
    end

    task automatic push_list(input logic [17:0] n, input logic [17:0] m, input logic [31:0] k,
                             input logic [35:0] c, input logic [3:0] bw, input logic [2:0] cp,
                             input bit en);
        logic [31:0] cd;
        exp_wr_q.push_back('{6'd0, 32'd0});
        exp_wr_q.push_back('{6'd3, {14'd0, n}});
        exp_wr_q.push_back('{6'd4, {14'd0, m}});
        exp_wr_q.push_back('{6'd7, k});
        for (int i = 0; i < NUM_C; i++) begin
            cd = {14'd0, c[i*18 +: 18]} + (i << 18);
            exp_wr_q.push_back('{6'd5, cd});
        end
        if (en) begin
            exp_wr_q.push_back('{6'd8, {28'd0, bw}});
            exp_wr_q.push_back('{6'd9, {29'd0, cp}});
        end
        exp_wr_q.push_back('{6'd2, 32'd1});
    endtask

    task automatic issue(input logic [17:0] n, input logic [17:0] m, input logic [31:0] k,
                         input logic [35:0] c, input logic [3:0] bw, input logic [2:0] cp,
                         input bit en, input int hold_cyc);
        bit d;
        int kk, t;
        push_list(n, m, k, c, bw, cp, en);
        predict(d, kk);
        exp_st_done = d;
        exp_st_k = kk;
        st_pending = 1'b1;
        @(posedge clk); #1;
        cfg_n = n; cfg_m = m; cfg_k = k; cfg_c = c; cfg_bw = bw; cfg_cp = cp; cfg_bwcp_en = en;
        cfg_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cfg_ready && t < 200);
        if (!cfg_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: cfg_ready stayed 0 for %0d cycles", t);
            finish_tb();
        end
        @(posedge clk); #1;
        // Keep asserting garbage requests while busy; they must not be queued
        for (int i = 0; i < hold_cyc; i++) begin
            cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_k = $urandom;
            cfg_bwcp_en = 1'($urandom);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_complete();
        int t;
        t = 0;
        while ((st_pending || exp_wr_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            tests++; fails++;
            $display("FAIL completion_timeout: pending=%0d writes_left=%0d", st_pending, exp_wr_q.size());
            finish_tb();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [35:0] rc;
        #3;
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_write", {31'd0, mgmt_write}, 32'd0);
        check("rst_addr", {26'd0, mgmt_address}, 32'd0);
        check("rst_data", mgmt_writedata, 32'd0);
        check("rst_status", {30'd0, done, error}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_first_edge", {31'd0, cfg_ready}, 32'd1);

        // Nominal list, immediate lock
        lock_mode = 0; wait_mode = 0;
        issue(18'h00404, 18'h20c0b, 32'h8000_0000, {18'h10101, 18'h00505}, 4'd0, 3'd0, 1'b0, 0);
        wait_complete();

        // M write stretched by five waitrequest cycles
        wait_mode = 1; check_m_len = 1'b1;
        issue(18'h00303, 18'h00808, 32'h1234_5678, {18'h00202, 18'h30a09}, 4'd0, 3'd0, 1'b0, 3);
        wait_complete();
        wait_mode = 0; check_m_len = 1'b0;

        // Bandwidth / charge-pump writes enabled
        issue(18'h00101, 18'h00606, 32'd0, {18'h00707, 18'h00404}, 4'd6, 3'd2, 1'b1, 0);
        wait_complete();

        // Lock glitch after a run of ten
        lock_mode = 1; lock_glitch = 9;
        issue(18'h00202, 18'h00a0a, 32'hdead_beef, {18'h00111, 18'h00222}, 4'd0, 3'd0, 1'b0, 0);
        wait_complete();

        // Lock stuck low: timeout
        lock_mode = 2;
        issue(18'h00505, 18'h00505, 32'd5, {18'h00005, 18'h00005}, 4'd1, 3'd1, 1'b1, 0);
        wait_complete();

        // Stable run completing exactly on the timeout cycle, then one cycle late
        lock_mode = 1; lock_glitch = 82;
        issue(18'h00a01, 18'h00b02, 32'd7, {18'h00c03, 18'h00d04}, 4'd0, 3'd0, 1'b0, 0);
        wait_complete();
        lock_glitch = 83;
        issue(18'h00a05, 18'h00b06, 32'd9, {18'h00c07, 18'h00d08}, 4'd0, 3'd0, 1'b0, 0);
        wait_complete();

        // Reset during the C0 write abandons the list
        lock_mode = 0;
        issue(18'h01111, 18'h02222, 32'h3333_4444, {18'h05555, 18'h06666}, 4'd0, 3'd0, 1'b0, 0);
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(mgmt_write && mgmt_address == 6'd5 && mgmt_writedata[22:18] == 5'd0) && t < 200);
            check("reached_c0_write", {31'd0, mgmt_write}, 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_write", {31'd0, mgmt_write}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_ready", {31'd0, cfg_ready}, 32'd0);
        exp_wr_q.delete();
        st_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, cfg_ready}, 32'd1);
        issue(18'h01111, 18'h02222, 32'h3333_4444, {18'h05555, 18'h06666}, 4'd0, 3'd0, 1'b0, 0);
        wait_complete();

        // Randomised requests, waitrequest and lock behaviour
        wait_mode = 2;
        for (int r = 0; r < 8; r++) begin
            lock_mode = $urandom_range(0, 2);
            lock_glitch = $urandom_range(1, 95);
            rc[31:0] = $urandom;
            rc[35:32] = 4'($urandom_range(0, 15));
            issue(18'($urandom), 18'($urandom), $urandom, rc, 4'($urandom), 3'($urandom),
                  1'($urandom), $urandom_range(0, 6));
            wait_complete();
        end

        finish_tb();
    end

endmodule
